// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: opcode and condition codes,
// instruction field positions and FSM state encodings.
package instruction_fetch_pkg;

  // Opcodes in bits [31:28]
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_JMP = 4'hF;

  // Jump conditions in bits [27:26]
  localparam logic [1:0] COND_UNC = 2'd0;
  localparam logic [1:0] COND_ZRO = 2'd1;
  localparam logic [1:0] COND_NZR = 2'd2;
  localparam logic [1:0] COND_NEG = 2'd3;

  // Field bit positions
  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 28;
  localparam int unsigned COND_MSB = 27;
  localparam int unsigned COND_LSB = 26;

  // Fetch FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Evaluate a jump condition against the current ALU flags
  function automatic logic cond_true(input logic [1:0] cond,
                                     input logic       fz,
                                     input logic       fn);
    logic res;
    unique case (cond)
      COND_UNC: res = 1'b1;
      COND_ZRO: res = fz;
      COND_NZR: res = !fz;
      default:  res = fn;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instruction_fetch_branch_unit.sv
// Combinational JMP resolution: flags a JMP word and selects the next PC
// (jump target when taken, PC+1 modulo 2^ADDR_W otherwise).
module fetch_branch_unit
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [3:0]        opcode,
  input  logic [1:0]        cond,
  input  logic              flag_zero,
  input  logic              flag_neg,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] target,
  output logic              is_jmp,
  output logic [ADDR_W-1:0] next_pc
);

  // Decode JMP and pick the successor address
  always_comb begin
    is_jmp  = (opcode == OP_JMP);
    next_pc = pc + ADDR_W'(1);
    if (is_jmp && cond_true(cond, flag_zero, flag_neg)) begin
      next_pc = target;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, the instruction register and the IDLE/RUN/HALT
// FSM; resolves JMP locally so decode never sees a JMP word.
// Optional feature macro: FETCH_BREAKPOINT_EN adds bp_addr/bp_enable/bp_hit.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               halt_req,
  input  logic               stall,
  input  logic               flag_zero,
  input  logic               flag_neg,
  input  logic [INSTR_W-1:0] instr_in,
`ifdef FETCH_BREAKPOINT_EN
  input  logic [ADDR_W-1:0]  bp_addr,
  input  logic               bp_enable,
  output logic               bp_hit,
`endif
  output logic [ADDR_W-1:0]  pc_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               running
);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, next_pc;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;
  logic               is_jmp, bp_trig, go_accept, fetch_en;

  assign go_accept = go && ((state_q == ST_IDLE) || (state_q == ST_HALT));
  assign fetch_en  = (state_q == ST_RUN) && !stall;

  fetch_branch_unit #(
    .ADDR_W (ADDR_W)
  ) u_branch (
    .opcode    (instr_in[OPC_MSB:OPC_LSB]),
    .cond      (instr_in[COND_MSB:COND_LSB]),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg),
    .pc        (pc_q),
    .target    (instr_in[ADDR_W-1:0]),
    .is_jmp    (is_jmp),
    .next_pc   (next_pc)
  );

`ifdef FETCH_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d, bp_skip_q, bp_skip_d;

  // The skip flag lets the word at bp_addr execute on the first RUN cycle after a resume
  assign bp_trig = bp_enable && (pc_q == bp_addr) && !bp_skip_q;
  assign bp_hit  = bp_hit_q;

  // Sticky hit flag, cleared by an accepted go; skip armed on resume from HALT
  always_comb begin
    bp_hit_d  = bp_hit_q;
    bp_skip_d = bp_skip_q;
    if (go_accept) begin
      bp_hit_d = 1'b0;
    end
    if (go && (state_q == ST_HALT)) begin
      bp_skip_d = 1'b1;
    end
    if (fetch_en) begin
      bp_skip_d = 1'b0;
      if (bp_trig) begin
        bp_hit_d = 1'b1;
      end
    end
  end

  // Breakpoint state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_hit_q  <= 1'b0;
      bp_skip_q <= 1'b0;
    end else begin
      bp_hit_q  <= bp_hit_d;
      bp_skip_q <= bp_skip_d;
    end
  end
`else
  assign bp_trig = 1'b0;
`endif

  // FSM transitions act even under stall; fetch/PC/IR only advance when not stalled
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: if (go) begin
        state_d = ST_RUN;
        pc_d    = ADDR_W'(RESET_PC);
      end
      ST_RUN:  if (halt_req) state_d = ST_HALT;
      ST_HALT: if (go) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    if (!stall) begin
      if (state_q == ST_RUN) begin
        if (bp_trig) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else if (is_jmp) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
        end else begin
          pc_d    = next_pc;
          ir_d    = instr_in;
          valid_d = 1'b1;
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // PC, instruction register, valid flag and FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  assign pc_addr     = pc_q;
  assign instr_out   = ir_q;
  assign instr_valid = valid_q;
  assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: behavioural instruction memory,
// directed scenarios, then randomized stimulus against a reference model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 32;

  localparam int MODE_IDLE = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_HALT = 2;

  logic          clk = 1'b0;
  logic          reset, go, halt_req, stall, flag_zero, flag_neg;
  logic [IW-1:0] instr_in, instr_out;
  logic [AW-1:0] pc_addr;
  logic          instr_valid, running;
`ifdef FETCH_BREAKPOINT_EN
  logic [AW-1:0] bp_addr;
  logic          bp_enable, bp_hit;
  bit            m_bp, m_skip;
`endif

  logic [IW-1:0] mem [256];
  assign instr_in = mem[pc_addr];

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .halt_req    (halt_req),
    .stall       (stall),
    .flag_zero   (flag_zero),
    .flag_neg    (flag_neg),
    .instr_in    (instr_in),
`ifdef FETCH_BREAKPOINT_EN
    .bp_addr     (bp_addr),
    .bp_enable   (bp_enable),
    .bp_hit      (bp_hit),
`endif
    .pc_addr     (pc_addr),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .running     (running)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // reference model state
  int            m_mode;
  int unsigned   m_pc;
  logic [31:0]   m_ir;
  bit            m_valid;
  logic [7:0]    seen[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_mov(input int unsigned imm);
    logic [7:0] i8;
    i8 = imm[7:0];
    return {OP_MOV, 2'b00, 9'd3, 9'd4, i8};
  endfunction

  function automatic logic [31:0] mk_jmp(input logic [1:0] cnd, input int unsigned tgt);
    logic [7:0] t8;
    t8 = tgt[7:0];
    return {OP_JMP, cnd, 18'd0, t8};
  endfunction

  task automatic load_program();
    for (int a = 0; a < 256; a++) begin
      if (a < 10)       mem[a] = mk_mov(2 * a + 1);
      else if (a == 10) mem[a] = mk_jmp(COND_UNC, 5);
      else              mem[a] = mk_mov(a);
    end
  endtask

  // One clock of the reference: next-state from the rules on the current state and inputs
  task automatic step_model(input bit rst, input bit g, input bit h, input bit s,
                            input bit fz, input bit fn);
    logic [31:0] w;
    int          n_mode;
    int unsigned n_pc;
    logic [31:0] n_ir;
    bit          n_valid, taken, brk;
    if (rst) begin
      m_mode = MODE_IDLE; m_pc = 0; m_ir = '0; m_valid = 0;
`ifdef FETCH_BREAKPOINT_EN
      m_bp = 0; m_skip = 0;
`endif
      return;
    end
    w = mem[m_pc];
    n_mode = m_mode; n_pc = m_pc; n_ir = m_ir; n_valid = m_valid;
    brk = 0;
    if (m_mode == MODE_IDLE && g) begin n_mode = MODE_RUN; n_pc = 0; end
    if (m_mode == MODE_RUN && h) n_mode = MODE_HALT;
    if (m_mode == MODE_HALT && g) n_mode = MODE_RUN;
`ifdef FETCH_BREAKPOINT_EN
    if (m_mode != MODE_RUN && g) m_bp = 0;
    brk = (m_mode == MODE_RUN) && !s && bp_enable && (m_pc == bp_addr) && !m_skip;
    if (m_mode == MODE_RUN && !s) m_skip = 0;
    if (m_mode == MODE_HALT && g) m_skip = 1;
    if (brk) m_bp = 1;
`endif
    if (!s) begin
      if (m_mode == MODE_RUN) begin
        if (brk) begin
          n_mode = MODE_HALT; n_valid = 0;
        end else if (w[31:28] == OP_JMP) begin
          case (w[27:26])
            COND_UNC: taken = 1;
            COND_ZRO: taken = fz;
            COND_NZR: taken = !fz;
            default:  taken = fn;
          endcase
          n_pc = taken ? int'(w[7:0]) : (m_pc + 1) % 256;
          n_valid = 0;
        end else begin
          n_ir = w; n_valid = 1; n_pc = (m_pc + 1) % 256;
        end
      end else begin
        n_valid = 0;
      end
    end
    m_mode = n_mode; m_pc = n_pc; m_ir = n_ir; m_valid = n_valid;
  endtask

  task automatic cycle(input bit rst, input bit g, input bit h, input bit s,
                       input bit fz, input bit fn);
    @(negedge clk);
    reset = rst; go = g; halt_req = h; stall = s; flag_zero = fz; flag_neg = fn;
    step_model(rst, g, h, s, fz, fn);
    @(posedge clk);
    #1;
    check("pc_addr", pc_addr, m_pc);
    check("instr_valid", instr_valid, m_valid);
    check("running", running, m_mode == MODE_RUN);
    check("instr_out", instr_out, m_ir);
    if (m_valid) check("no_jmp_out", instr_out[31:28] == OP_JMP, 0);
`ifdef FETCH_BREAKPOINT_EN
    check("bp_hit", bp_hit, m_bp);
`endif
    if (instr_valid) seen.push_back(instr_out[7:0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_until(input int unsigned target, input bit fz);
    int n = 0;
    while (m_pc != target && n < 300) begin
      cycle(0, 0, 0, 0, fz, 0);
      n++;
    end
    check("wait_pc", pc_addr, target);
  endtask

  task automatic restart();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; go = 0; halt_req = 0; stall = 0; flag_zero = 0; flag_neg = 0;
`ifdef FETCH_BREAKPOINT_EN
    bp_addr = '0; bp_enable = 0;
`endif
    load_program();

    // 1: reset held 3 cycles (go/halt asserted must not matter), then no go
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    idle(3);
    check("t1_pc", pc_addr, 0);
    check("t1_running", running, 0);

    // 2: go, MOV imm 1..19 then JMP to 5 loop
    seen.delete();
    cycle(0, 1, 0, 0, 0, 0);
    idle(20);
    check("t2_count", seen.size() >= 15, 1);
    for (int k = 0; k < 15 && k < seen.size(); k++)
      check("t2_seq", seen[k], (k < 10) ? 2 * k + 1 : 11 + 2 * (k - 10));

    // 3: stall while PC=3
    restart();
    run_until(3, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      check("t3_pc_hold", pc_addr, 3);
      check("t3_ir_hold", instr_out[7:0], 5);
    end
    cycle(0, 0, 0, 0, 0, 0);
    check("t3_resume", instr_out[7:0], 7);

    // 4: halt at PC=6, resume 4 cycles later
    run_until(6, 0);
    cycle(0, 0, 1, 0, 0, 0);
    check("t4_running", running, 0);
    check("t4_pc", pc_addr, 7);
    idle(4);
    check("t4_pc_held", pc_addr, 7);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("t4_valid", instr_valid, 1);
    check("t4_imm", instr_out[7:0], 15);

    // 5: conditional JMP at addr 2, then wrap through 255
    mem[2] = mk_jmp(COND_ZRO, 8);
    restart();
    run_until(2, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("t5_fall", pc_addr, 3);
    check("t5_fall_bubble", instr_valid, 0);
    restart();
    run_until(2, 1);
    cycle(0, 0, 0, 0, 1, 0);
    check("t5_taken", pc_addr, 8);
    mem[9]   = mk_jmp(COND_UNC, 255);
    mem[255] = mk_mov(8'h77);
    run_until(255, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("t5_wrap", pc_addr, 0);
    check("t5_wrap_imm", instr_out[7:0], 8'h77);
    load_program();

`ifdef FETCH_BREAKPOINT_EN
    // 6: breakpoint at 4
    bp_addr = 8'd4; bp_enable = 1;
    restart();
    for (int n = 0; n < 20 && m_mode == MODE_RUN; n++) cycle(0, 0, 0, 0, 0, 0);
    check("t6_pc", pc_addr, 4);
    check("t6_hit", bp_hit, 1);
    check("t6_running", running, 0);
    cycle(0, 1, 0, 0, 0, 0);
    check("t6_hit_clr", bp_hit, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("t6_imm", instr_out[7:0], 9);
    check("t6_valid", instr_valid, 1);
    bp_enable = 0;
`endif

    // randomized program and control
    for (int a = 0; a < 256; a++) begin
      if ($urandom_range(3) == 0)
        mem[a] = mk_jmp(2'($urandom_range(3)), $urandom_range(255));
      else
        mem[a] = {($urandom_range(1) == 0) ? OP_MOV : OP_ADD, 28'($urandom)};
    end
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
`ifdef FETCH_BREAKPOINT_EN
      if ($urandom_range(31) == 0) begin
        bp_enable = ($urandom_range(3) == 0);
        bp_addr   = 8'($urandom_range(255));
      end
`endif
      cycle($urandom_range(199) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0,
            $urandom_range(4) == 0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
